// File: rtl/res_reader.sv
// Result reader: streams row_num rows from one SRAM bank group (0-3 or 4-7)
// and presents them to the systolic array with a per-column forward skew.
module res_reader #(
  parameter int COL_NUM    = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           pingpang,
  input  logic [10:0]                    row_num,
  output logic                           bce0,
  output logic                           bce1,
  output logic                           bce2,
  output logic                           bce3,
  output logic                           bce4,
  output logic                           bce5,
  output logic                           bce6,
  output logic                           bce7,
  output logic [14:0]                    braddr0,
  output logic [14:0]                    braddr1,
  output logic [14:0]                    braddr2,
  output logic [14:0]                    braddr3,
  output logic [14:0]                    braddr4,
  output logic [14:0]                    braddr5,
  output logic [14:0]                    braddr6,
  output logic [14:0]                    braddr7,
  input  logic [127:0]                   brdata0,
  input  logic [127:0]                   brdata1,
  input  logic [127:0]                   brdata2,
  input  logic [127:0]                   brdata3,
  input  logic [127:0]                   brdata4,
  input  logic [127:0]                   brdata5,
  input  logic [127:0]                   brdata6,
  input  logic [127:0]                   brdata7,
  output logic [COL_NUM*DATA_WIDTH-1:0]  array_data_out,
  output logic                           array_valid_out,
  output logic                           busy,
  output logic                           done
);

  localparam int ROW_W = COL_NUM * DATA_WIDTH;
  localparam int DW_W  = $clog2(COL_NUM);
  // Drain waits until the last row's final column has left the skew chain.
  localparam logic [DW_W-1:0] DRAIN_LEN = DW_W'(COL_NUM - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic              pp_r;
  logic [10:0]       row_num_r;
  logic [10:0]       cnt_r;
  logic [DW_W-1:0]   drain_r;
  logic [7:0]        bce_r;
  logic [14:0]       braddr_r [0:7];
  logic              busy_r;
  logic              done_r;
  logic [ROW_W-1:0]  raw_r;
  logic              raw_valid_r;

  logic [7:0]        sel_mask_s;
  logic              rd_ret_s;
  logic [ROW_W-1:0]  sel_data_s;

  // Bank-group selection and read-return steering for the captured ping-pong side.
  always_comb begin
    sel_mask_s = 8'h00;
    rd_ret_s   = 1'b0;
    sel_data_s = {ROW_W{1'b0}};
    if (pp_r) begin
      sel_mask_s = 8'hF0;
      rd_ret_s   = bce_r[4];
      sel_data_s = {brdata7, brdata6, brdata5, brdata4};
    end else begin
      sel_mask_s = 8'h0F;
      rd_ret_s   = bce_r[0];
      sel_data_s = {brdata3, brdata2, brdata1, brdata0};
    end
  end

  // Control FSM: request capture, read issue, drain timing and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pp_r      <= 1'b0;
      row_num_r <= 11'd0;
      cnt_r     <= 11'd0;
      drain_r   <= {DW_W{1'b0}};
      bce_r     <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        braddr_r[k] <= 15'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          bce_r  <= 8'h00;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (start) begin
            pp_r      <= pingpang;
            row_num_r <= row_num;
            cnt_r     <= 11'd0;
            state_r   <= (row_num != 11'd0) ? READ : DONE;
          end
        end
        READ: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          bce_r  <= sel_mask_s;
          for (int k = 0; k < 8; k++) begin
            if (sel_mask_s[k]) begin
              braddr_r[k] <= {cnt_r, 4'b0000};
            end
          end
          cnt_r <= cnt_r + 11'd1;
          if (cnt_r == row_num_r - 11'd1) begin
            drain_r <= DRAIN_LEN;
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          bce_r  <= 8'h00;
          if (drain_r == {DW_W{1'b0}}) begin
            state_r <= DONE;
          end else begin
            drain_r <= drain_r - {{(DW_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          busy_r  <= 1'b1;
          done_r  <= 1'b1;
          bce_r   <= 8'h00;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          bce_r   <= 8'h00;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Raw row capture one cycle after each read; empty slots are forced to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_r       <= {ROW_W{1'b0}};
      raw_valid_r <= 1'b0;
    end else if (rd_ret_s) begin
      raw_r       <= sel_data_s;
      raw_valid_r <= 1'b1;
    end else begin
      raw_r       <= {ROW_W{1'b0}};
      raw_valid_r <= 1'b0;
    end
  end

  assign array_data_out[DATA_WIDTH-1:0] = raw_r[DATA_WIDTH-1:0];

  for (genvar i = 1; i < COL_NUM; i++) begin : g_skew
    logic [DATA_WIDTH-1:0] pipe_r [0:i-1];

    // Column i delay line of i stages, shifting every cycle.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j < i; j++) begin
          pipe_r[j] <= {DATA_WIDTH{1'b0}};
        end
      end else begin
        pipe_r[0] <= raw_r[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j < i; j++) begin
          pipe_r[j] <= pipe_r[j-1];
        end
      end
    end

    assign array_data_out[i*DATA_WIDTH +: DATA_WIDTH] = pipe_r[i-1];
  end

  assign array_valid_out = raw_valid_r;
  assign busy            = busy_r;
  assign done            = done_r;

  assign bce0 = bce_r[0];
  assign bce1 = bce_r[1];
  assign bce2 = bce_r[2];
  assign bce3 = bce_r[3];
  assign bce4 = bce_r[4];
  assign bce5 = bce_r[5];
  assign bce6 = bce_r[6];
  assign bce7 = bce_r[7];

  assign braddr0 = braddr_r[0];
  assign braddr1 = braddr_r[1];
  assign braddr2 = braddr_r[2];
  assign braddr3 = braddr_r[3];
  assign braddr4 = braddr_r[4];
  assign braddr5 = braddr_r[5];
  assign braddr6 = braddr_r[6];
  assign braddr7 = braddr_r[7];

endmodule
